// File: rtl/spart_bus_pkg.sv
// Shared status-word layout and address constant for the SPART bus responder.
// The status word carries valid, overflow, post-pop count and the received byte.
`timescale 1ns/1ps
package spart_bus_pkg;

  localparam int VALID_BIT = 15;
  localparam int OVF_BIT   = 14;
  localparam int CNT_LSB   = 11;
  localparam int CNT_W     = 3;
  localparam int BUS_W     = 16;

  localparam logic [3:0] SPART_CS_ADDR = 4'b0011;

  function automatic logic [BUS_W-1:0] pack_status(
    input logic             valid,
    input logic             ovf,
    input logic [CNT_W-1:0] cnt,
    input logic [7:0]       data
  );
    logic [BUS_W-1:0] w;
    w = '0;
    w[VALID_BIT]                 = valid;
    w[OVF_BIT]                   = ovf;
    w[CNT_LSB +: CNT_W]          = cnt;
    w[7:0]                       = data;
    return w;
  endfunction

endpackage

// File: rtl/bus_rx_fifo.sv
// Circular receive FIFO: pop takes effect on the same edge as a push, so a full FIFO
// still accepts a byte when it is read in that cycle. Push while full is ignored.
`timescale 1ns/1ps
module bus_rx_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [2:0]        count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]        count_q, count_d;
  logic              pop_en, push_en;

  assign empty   = (count_q == 3'd0);
  assign full    = (count_q == 3'(DEPTH));
  assign pop_en  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_en = push & (~full | pop_en);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + 3'(push_en) - 3'(pop_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/spart_bus_responder.sv
// SPART read responder: the first cycle of CS pops one byte and latches a status word,
// which is driven onto DataBus for every following cycle CS stayed high; otherwise Z.
`timescale 1ns/1ps
module spart_bus_responder
  import spart_bus_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  inout  wire  [15:0]       DataBus,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [2:0]        fifo_count,
  output logic              overflow
);

  logic              cs_q, cs_d;
  logic [15:0]       rd_word_q, rd_word_d;
  logic              overflow_q, overflow_d;
  logic              rd_evt;
  logic              drive_en;
  logic              drop;
  logic [DATA_W-1:0] head;
  logic [2:0]        count;
  logic              full;
  logic              empty;

  bus_rx_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rd_evt),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign rd_evt   = CS & ~cs_q;
  assign drive_en = cs_q;
  // A read on a full FIFO always pops, so only a read-free push can be dropped.
  assign drop     = rx_valid & full & ~rd_evt;

  always_comb begin
    cs_d       = CS;
    rd_word_d  = rd_word_q;
    overflow_d = overflow_q;
    if (rd_evt) begin
      rd_word_d  = pack_status(~empty, overflow_q, count - {2'b00, ~empty},
                               empty ? 8'h00 : head);
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q       <= 1'b0;
      rd_word_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      cs_q       <= cs_d;
      rd_word_q  <= rd_word_d;
      overflow_q <= overflow_d;
    end
  end

  assign DataBus    = drive_en ? rd_word_q : 16'hzzzz;
  assign fifo_count = count;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_spart_bus_responder.sv
// Bench for spart_bus_responder: vector table, hand sequences for held CS and
// mid-response reset, then random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_spart_bus_responder;

  localparam int          DEPTH = 4;
  // Undriven bus reads back as all ones through the pull-ups.
  localparam logic [15:0] BUS_Z = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        rx_valid;
  logic [7:0]  rx_data;
  wire  [15:0] data_bus;
  logic [2:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (data_bus[i]);
  end

  spart_bus_responder #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .CS         (cs),
    .DataBus    (data_bus),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [7:0]  d;
    logic        rd;
    logic [15:0] bus;
    logic [2:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic p, input logic [7:0] d, input logic r,
                     input logic [15:0] bus, input logic [2:0] cnt, input logic ovf);
    vec_t v;
    v.push = p; v.d = d; v.rd = r; v.bus = bus; v.cnt = cnt; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    cs = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic chk_state(input string name, input logic [15:0] bus,
                           input logic [2:0] cnt, input logic ovf);
    chk({name, " bus"}, data_bus, bus);
    chk({name, " cnt"}, {13'd0, fifo_count}, {13'd0, cnt});
    chk({name, " ovf"}, {15'd0, overflow}, {15'd0, ovf});
  endtask

  // Random-phase model state
  byte unsigned mq[$];
  logic         m_ovf;
  logic         m_cs;
  logic [15:0]  m_word;

  initial begin
    do_reset();
    chk_state("reset", BUS_Z, 3'd0, 1'b0);

    // push, data, read  ->  bus, count, overflow seen after the edge
    add(0, 8'h00, 0, BUS_Z,   0, 0);
    add(0, 8'h00, 1, 16'h0000, 0, 0);
    add(0, 8'h00, 0, BUS_Z,   0, 0);
    add(1, 8'hA5, 0, BUS_Z,   1, 0);
    add(1, 8'h3C, 0, BUS_Z,   2, 0);
    add(0, 8'h00, 1, 16'h88A5, 1, 0);
    add(0, 8'h00, 0, BUS_Z,   1, 0);
    add(0, 8'h00, 1, 16'h803C, 0, 0);
    add(0, 8'h00, 0, BUS_Z,   0, 0);
    add(0, 8'h00, 1, 16'h0000, 0, 0);
    add(0, 8'h00, 0, BUS_Z,   0, 0);
    add(1, 8'h01, 0, BUS_Z,   1, 0);
    add(1, 8'h02, 0, BUS_Z,   2, 0);
    add(1, 8'h03, 0, BUS_Z,   3, 0);
    add(1, 8'h04, 0, BUS_Z,   4, 0);
    add(1, 8'h05, 0, BUS_Z,   4, 1);
    add(0, 8'h00, 1, 16'hD801, 3, 0);
    add(0, 8'h00, 0, BUS_Z,   3, 0);
    add(0, 8'h00, 1, 16'h9002, 2, 0);
    add(0, 8'h00, 0, BUS_Z,   2, 0);
    add(0, 8'h00, 1, 16'h8803, 1, 0);
    add(0, 8'h00, 0, BUS_Z,   1, 0);
    add(0, 8'h00, 1, 16'h8004, 0, 0);
    add(0, 8'h00, 0, BUS_Z,   0, 0);
    add(1, 8'h10, 0, BUS_Z,   1, 0);
    add(1, 8'h11, 0, BUS_Z,   2, 0);
    add(1, 8'h12, 0, BUS_Z,   3, 0);
    add(1, 8'h13, 0, BUS_Z,   4, 0);
    add(1, 8'h77, 1, 16'h9810, 4, 0);
    add(0, 8'h00, 0, BUS_Z,   4, 0);
    add(0, 8'h00, 1, 16'h9811, 3, 0);
    add(0, 8'h00, 0, BUS_Z,   3, 0);
    add(0, 8'h00, 1, 16'h9012, 2, 0);
    add(0, 8'h00, 0, BUS_Z,   2, 0);
    add(0, 8'h00, 1, 16'h8813, 1, 0);
    add(0, 8'h00, 0, BUS_Z,   1, 0);
    add(0, 8'h00, 1, 16'h8077, 0, 0);
    add(0, 8'h00, 0, BUS_Z,   0, 0);
    add(1, 8'h55, 1, 16'h0000, 1, 0);
    add(0, 8'h00, 0, BUS_Z,   1, 0);
    add(0, 8'h00, 1, 16'h8055, 0, 0);
    add(0, 8'h00, 0, BUS_Z,   0, 0);
    add(1, 8'h61, 0, BUS_Z,   1, 0);
    add(1, 8'h62, 0, BUS_Z,   2, 0);
    add(1, 8'h63, 0, BUS_Z,   3, 0);
    add(1, 8'h64, 0, BUS_Z,   4, 0);
    add(1, 8'h65, 0, BUS_Z,   4, 1);
    add(1, 8'h66, 1, 16'hD861, 4, 0);
    add(0, 8'h00, 0, BUS_Z,   4, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rx_valid = tbl[i].push;
      rx_data  = tbl[i].d;
      cs       = tbl[i].rd;
      tick();
      chk_state($sformatf("vec%0d", i), tbl[i].bus, tbl[i].cnt, tbl[i].ovf);
    end
    rx_valid = 1'b0;
    cs       = 1'b0;

    // CS held three cycles: one pop, same word on every drive cycle
    do_reset();
    rx_valid = 1'b1; rx_data = 8'h11; tick();
    rx_data = 8'h22; tick();
    rx_valid = 1'b0;
    chk("hold pre bus", data_bus, BUS_Z);
    cs = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_state($sformatf("hold%0d", k), 16'h8811, 3'd1, 1'b0);
    end
    cs = 1'b0;
    tick();
    chk_state("hold post", BUS_Z, 3'd1, 1'b0);

    // Reset asserted between edges while driving, with overflow set
    do_reset();
    rx_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rx_data = 8'h21 + 8'(k);
      tick();
    end
    rx_valid = 1'b0;
    cs = 1'b1;
    tick();
    chk_state("mid rd", 16'hD821, 3'd3, 1'b0);
    rx_valid = 1'b1; rx_data = 8'h26; tick();
    rx_data = 8'h27; tick();
    rx_valid = 1'b0;
    chk_state("mid drop", 16'hD821, 3'd4, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_state("mid async", BUS_Z, 3'd0, 1'b0);
    cs = 1'b0;
    rst = 1'b1;
    tick();
    chk_state("mid release", BUS_Z, 3'd0, 1'b0);

    // Randomized traffic against a queue model
    do_reset();
    mq.delete();
    m_ovf = 1'b0; m_cs = 1'b0; m_word = 16'h0000;
    for (int n = 0; n < 2000; n++) begin
      logic        p, c, v;
      logic [7:0]  d, hd;
      logic [2:0]  cn;
      logic [15:0] exp_bus;
      p = ($urandom_range(0, 9) < 6);
      c = ($urandom_range(0, 9) < 4);
      d = 8'($urandom);
      rx_valid = p; rx_data = d; cs = c;
      if (c && !m_cs) begin
        v  = (mq.size() != 0);
        hd = v ? mq[0] : 8'h00;
        cn = 3'(mq.size() - (v ? 1 : 0));
        m_word = {v, m_ovf, cn, 3'b000, hd};
        if (v) void'(mq.pop_front());
        m_ovf = 1'b0;
      end
      if (p) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
      exp_bus = c ? m_word : BUS_Z;
      m_cs = c;
      tick();
      chk_state($sformatf("rnd%0d", n), exp_bus, 3'(mq.size()), m_ovf);
    end
    rx_valid = 1'b0;
    cs = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
